// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one add/sub cell and a carry/borrow flop, LSB first.
// Optional signed-overflow output is built when SERIAL_OVF_EN is defined.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    // state | meaning
    // IDLE  | waiting for start; outputs hold last result
    // RUN   | one bit per cycle through the add/sub cell
    // DONE  | single-cycle done pulse, result/cout valid
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-1:0] result_shift;
    logic [CW-1:0]    cnt;
    logic             mode_q;
    logic             c;
    logic             ai, bi, s, c_nxt, last;

    assign ai    = a_sh[0];
    assign bi    = b_sh[0];
    assign s     = ai ^ bi ^ c;
    assign c_nxt = mode_q ? ((~ai & bi) | (bi & c) | (c & ~ai))
                          : ((ai & bi) | (bi & c) | (c & ai));
    assign last  = (cnt == CW'(WIDTH - 1));

    generate
        if (WIDTH == 1) begin : g_w1
            assign result_shift = s;
        end else begin : g_wn
            assign result_shift = {s, result[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DONE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            mode_q <= 1'b0;
            c      <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        mode_q <= mode;
                        c      <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    c      <= c_nxt;
                    cnt    <= cnt + 1'b1;
                    result <= result_shift;
                    if (last) cout <= c_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_OVF_EN
    // On the final RUN edge c is the carry/borrow into the MSB, c_nxt the one out.
    always_ff @(posedge clk) begin
        if (!rst_n)                   ovf <= 1'b0;
        else if (state == RUN && last) ovf <= c ^ c_nxt;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule
